fwvexrisc_simplebus_wb_bridge: RTL and testbench

//  Bridges the VexRiscv simple iBus/dBus to one 32-bit Wishbone initiator port.

---
 rtl/fwvexrisc_simplebus_wb_bridge_if.sv | 52 +++++
 rtl/fwvexrisc_simplebus_wb_bridge.sv | 182 ++++++++++++++++++
 tb/tb_fwvexrisc_simplebus_wb_bridge.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fwvexrisc_simplebus_wb_bridge_if.sv
// Core-side simple iBus/dBus and Wishbone initiator signals of the fwvexrisc bridge.
// The bridge uses the slave view; the core/interconnect side uses the master view.
interface fwvexrisc_simplebus_wb_bridge_if #(
  parameter int ADR_WIDTH = 32
);
  logic                 iBus_cmd_valid;
  logic                 iBus_cmd_ready;
  logic [31:0]          iBus_cmd_payload_pc;
  logic                 iBus_rsp_valid;
  logic                 iBus_rsp_payload_error;
  logic [31:0]          iBus_rsp_payload_inst;

  logic                 dBus_cmd_valid;
  logic                 dBus_cmd_ready;
  logic                 dBus_cmd_payload_wr;
  logic [31:0]          dBus_cmd_payload_address;
  logic [31:0]          dBus_cmd_payload_data;
  logic [1:0]           dBus_cmd_payload_size;
  logic                 dBus_rsp_ready;
  logic                 dBus_rsp_error;
  logic [31:0]          dBus_rsp_data;

  logic [ADR_WIDTH-1:0] i_adr;
  logic [31:0]          i_dat_w;
  logic [31:0]          i_dat_r;
  logic                 i_cyc;
  logic                 i_stb;
  logic                 i_we;
  logic [3:0]           i_sel;
  logic                 i_ack;
  logic                 i_err;

  modport slave (
    input  iBus_cmd_valid, iBus_cmd_payload_pc,
    output iBus_cmd_ready, iBus_rsp_valid, iBus_rsp_payload_error, iBus_rsp_payload_inst,
    input  dBus_cmd_valid, dBus_cmd_payload_wr, dBus_cmd_payload_address,
    input  dBus_cmd_payload_data, dBus_cmd_payload_size,
    output dBus_cmd_ready, dBus_rsp_ready, dBus_rsp_error, dBus_rsp_data,
    output i_adr, i_dat_w, i_cyc, i_stb, i_we, i_sel,
    input  i_dat_r, i_ack, i_err
  );

  modport master (
    output iBus_cmd_valid, iBus_cmd_payload_pc,
    input  iBus_cmd_ready, iBus_rsp_valid, iBus_rsp_payload_error, iBus_rsp_payload_inst,
    output dBus_cmd_valid, dBus_cmd_payload_wr, dBus_cmd_payload_address,
    output dBus_cmd_payload_data, dBus_cmd_payload_size,
    input  dBus_cmd_ready, dBus_rsp_ready, dBus_rsp_error, dBus_rsp_data,
    input  i_adr, i_dat_w, i_cyc, i_stb, i_we, i_sel,
    output i_dat_r, i_ack, i_err
  );
endinterface

// File: rtl/fwvexrisc_simplebus_wb_bridge.sv
// Bridges the VexRiscv simple iBus/dBus onto a single Wishbone initiator with
// selectable arbitration, post-response turnaround, err propagation and timeout abort.
module fwvexrisc_simplebus_wb_bridge #(
  parameter int ADR_WIDTH  = 32,
  parameter int ARB_MODE   = 0,
  parameter int TURNAROUND = 2,
  parameter int TIMEOUT    = 0
) (
  input  logic                              clock,
  input  logic                              reset,
  fwvexrisc_simplebus_wb_bridge_if.slave    bus
);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_INST, S_TURN} state_t;

  // One counter serves both the timeout (in DATA/INST) and the turnaround (in TURN).
  localparam int CNT_W = (TIMEOUT > 7) ? $clog2(TIMEOUT + 1) : 3;
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'((TURNAROUND > 0) ? TURNAROUND - 1 : 0);

  state_t               state_q, state_d;
  logic                 last_i_q, last_i_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ADR_WIDTH-1:0] adr_q, adr_d;
  logic [31:0]          dat_w_q, dat_w_d;
  logic                 we_q, we_d;
  logic [3:0]           sel_q, sel_d;
  logic                 cyc_q, cyc_d;
  logic                 i_rsp_valid_q, i_rsp_valid_d;
  logic                 i_rsp_err_q, i_rsp_err_d;
  logic [31:0]          i_inst_q, i_inst_d;
  logic                 d_rsp_ready_q, d_rsp_ready_d;
  logic                 d_rsp_err_q, d_rsp_err_d;
  logic [31:0]          d_rsp_data_q, d_rsp_data_d;

  logic pick_d;
  logic d_ready;
  logic i_ready;
  logic done;
  logic timed_out;

  function automatic logic [3:0] byte_sel(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'd0:    byte_sel = 4'b0001 << a;
      2'd1:    byte_sel = a[1] ? 4'b1100 : 4'b0011;
      default: byte_sel = 4'b1111;
    endcase
  endfunction

  always_comb begin
    // With no conflicting requests, the round-robin preference still decides which ready is shown.
    if (ARB_MODE == 0) begin
      pick_d = bus.dBus_cmd_valid | ~bus.iBus_cmd_valid;
    end else if (bus.dBus_cmd_valid & bus.iBus_cmd_valid) begin
      pick_d = last_i_q;
    end else begin
      pick_d = bus.dBus_cmd_valid | (~bus.iBus_cmd_valid & last_i_q);
    end
    d_ready   = (state_q == S_IDLE) & pick_d & ~reset;
    i_ready   = (state_q == S_IDLE) & ~pick_d & ~reset;
    done      = bus.i_ack | bus.i_err;
    timed_out = (TIMEOUT > 0) && !done && (cnt_q == TO_LAST);
  end

  always_comb begin
    state_d       = state_q;
    last_i_d      = last_i_q;
    cnt_d         = cnt_q;
    adr_d         = adr_q;
    dat_w_d       = dat_w_q;
    we_d          = we_q;
    sel_d         = sel_q;
    cyc_d         = cyc_q;
    i_rsp_valid_d = 1'b0;
    i_rsp_err_d   = i_rsp_err_q;
    i_inst_d      = i_inst_q;
    d_rsp_ready_d = 1'b0;
    d_rsp_err_d   = d_rsp_err_q;
    d_rsp_data_d  = d_rsp_data_q;

    case (state_q)
      S_IDLE: begin
        if (d_ready & bus.dBus_cmd_valid) begin
          adr_d    = bus.dBus_cmd_payload_address[ADR_WIDTH-1:0];
          dat_w_d  = bus.dBus_cmd_payload_data;
          we_d     = bus.dBus_cmd_payload_wr;
          sel_d    = byte_sel(bus.dBus_cmd_payload_size, bus.dBus_cmd_payload_address[1:0]);
          cyc_d    = 1'b1;
          cnt_d    = '0;
          last_i_d = 1'b0;
          state_d  = S_DATA;
        end else if (i_ready & bus.iBus_cmd_valid) begin
          adr_d    = bus.iBus_cmd_payload_pc[ADR_WIDTH-1:0];
          dat_w_d  = '0;
          we_d     = 1'b0;
          sel_d    = 4'b1111;
          cyc_d    = 1'b1;
          cnt_d    = '0;
          last_i_d = 1'b1;
          state_d  = S_INST;
        end
      end
      S_DATA, S_INST: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (done | timed_out) begin
          cyc_d   = 1'b0;
          cnt_d   = '0;
          state_d = (TURNAROUND > 0) ? S_TURN : S_IDLE;
          // err dominates ack; a timeout reports an error with zeroed data.
          if (state_q == S_DATA) begin
            d_rsp_ready_d = 1'b1;
            d_rsp_err_d   = bus.i_err | timed_out;
            d_rsp_data_d  = done ? bus.i_dat_r : 32'h0;
          end else begin
            i_rsp_valid_d = 1'b1;
            i_rsp_err_d   = bus.i_err | timed_out;
            i_inst_d      = done ? bus.i_dat_r : 32'h0;
          end
        end
      end
      S_TURN: begin
        if (cnt_q == TURN_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      last_i_q      <= 1'b1;
      cnt_q         <= '0;
      adr_q         <= '0;
      dat_w_q       <= '0;
      we_q          <= 1'b0;
      sel_q         <= '0;
      cyc_q         <= 1'b0;
      i_rsp_valid_q <= 1'b0;
      i_rsp_err_q   <= 1'b0;
      i_inst_q      <= '0;
      d_rsp_ready_q <= 1'b0;
      d_rsp_err_q   <= 1'b0;
      d_rsp_data_q  <= '0;
    end else begin
      state_q       <= state_d;
      last_i_q      <= last_i_d;
      cnt_q         <= cnt_d;
      adr_q         <= adr_d;
      dat_w_q       <= dat_w_d;
      we_q          <= we_d;
      sel_q         <= sel_d;
      cyc_q         <= cyc_d;
      i_rsp_valid_q <= i_rsp_valid_d;
      i_rsp_err_q   <= i_rsp_err_d;
      i_inst_q      <= i_inst_d;
      d_rsp_ready_q <= d_rsp_ready_d;
      d_rsp_err_q   <= d_rsp_err_d;
      d_rsp_data_q  <= d_rsp_data_d;
    end
  end

  assign bus.iBus_cmd_ready         = i_ready;
  assign bus.dBus_cmd_ready         = d_ready;
  assign bus.iBus_rsp_valid         = i_rsp_valid_q;
  assign bus.iBus_rsp_payload_error = i_rsp_err_q;
  assign bus.iBus_rsp_payload_inst  = i_inst_q;
  assign bus.dBus_rsp_ready         = d_rsp_ready_q;
  assign bus.dBus_rsp_error         = d_rsp_err_q;
  assign bus.dBus_rsp_data          = d_rsp_data_q;
  assign bus.i_adr                  = adr_q;
  assign bus.i_dat_w                = dat_w_q;
  assign bus.i_cyc                  = cyc_q;
  assign bus.i_stb                  = cyc_q;
  assign bus.i_we                   = we_q;
  assign bus.i_sel                  = sel_q;

endmodule

// File: tb/tb_fwvexrisc_simplebus_wb_bridge.sv
// Bench for the simple-bus to Wishbone bridge: directed table, corner sequences and
// randomized transactions checked against a transaction-level reference model.
module tb_fwvexrisc_simplebus_wb_bridge;
  localparam int ARB  = 1;
  localparam int TURN = 2;
  localparam int TO   = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  fwvexrisc_simplebus_wb_bridge_if #(.ADR_WIDTH(32)) bus_a ();
  fwvexrisc_simplebus_wb_bridge_if #(.ADR_WIDTH(32)) bus_b ();

  fwvexrisc_simplebus_wb_bridge #(.ADR_WIDTH(32), .ARB_MODE(ARB), .TURNAROUND(TURN), .TIMEOUT(TO))
    dut_a (.clock(clock), .reset(reset), .bus(bus_a));

  // Second instance: fixed priority, no turnaround, no timeout, slave acks as soon as it sees cyc.
  fwvexrisc_simplebus_wb_bridge #(.ADR_WIDTH(32), .ARB_MODE(0), .TURNAROUND(0), .TIMEOUT(0))
    dut_b (.clock(clock), .reset(reset), .bus(bus_b));
  assign bus_b.i_ack = bus_b.i_cyc;

  int passed = 0;
  int total  = 0;

  logic        m_last_i;
  logic [31:0] m_d_data, m_i_inst;
  logic [3:0]  obs_sel;
  logic        obs_we, obs_d;
  logic [31:0] obs_datw;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          dly;
    logic [3:0]  exp_sel;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  function automatic logic model_pick_d(input logic iv, input logic dv, input logic last_i);
    if (iv && !dv) return 1'b0;
    if (dv && !iv) return 1'b1;
    return (ARB == 0) ? 1'b1 : last_i;
  endfunction

  // Byte lanes covered by an aligned access of 1, 2 or 4 bytes.
  function automatic logic [3:0] model_sel(input logic [1:0] size, input logic [1:0] a);
    int nbytes, base;
    logic [3:0] s;
    nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    base   = int'(a) - (int'(a) % nbytes);
    s = '0;
    for (int b = 0; b < 4; b++) s[b] = (b >= base) && (b < base + nbytes);
    return s;
  endfunction

  task automatic run_txn(input logic iv, input logic dv, input logic [31:0] pc,
                         input logic wr, input logic [31:0] addr, input logic [1:0] size,
                         input logic [31:0] wdata, input logic [31:0] rdata,
                         input int dly, input logic err, input logic noack);
    logic gd, granted, hold_ok, done, pulse_ok, exp_err;
    logic [3:0]  esel;
    logic [31:0] eadr, edatw, exp_data;
    int n;
    check("held_d_data", bus_a.dBus_rsp_data, m_d_data);
    check("held_i_inst", bus_a.iBus_rsp_payload_inst, m_i_inst);
    bus_a.i_dat_r = rdata;
    @(negedge clock);
    bus_a.iBus_cmd_valid = iv;
    bus_a.iBus_cmd_payload_pc = pc;
    bus_a.dBus_cmd_valid = dv;
    bus_a.dBus_cmd_payload_wr = wr;
    bus_a.dBus_cmd_payload_address = addr;
    bus_a.dBus_cmd_payload_size = size;
    bus_a.dBus_cmd_payload_data = wdata;
    granted = 1'b0;
    n = 0;
    while (!granted && n < 16) begin
      #1;
      if ((iv && bus_a.iBus_cmd_ready) || (dv && bus_a.dBus_cmd_ready)) granted = 1'b1;
      else begin n++; @(negedge clock); end
    end
    check("grant_seen", granted, 1);
    if (!granted) begin
      bus_a.iBus_cmd_valid = 1'b0;
      bus_a.dBus_cmd_valid = 1'b0;
      return;
    end
    gd = dv && bus_a.dBus_cmd_ready;
    check("arb", gd, model_pick_d(iv, dv, m_last_i));
    check("one_ready", bus_a.iBus_cmd_ready ^ bus_a.dBus_cmd_ready, 1);
    m_last_i = !gd;
    esel  = gd ? model_sel(size, addr[1:0]) : 4'b1111;
    eadr  = gd ? addr : pc;
    edatw = gd ? wdata : 32'h0;
    @(posedge clock); #1;
    bus_a.iBus_cmd_valid = 1'b0;
    bus_a.dBus_cmd_valid = 1'b0;
    check("cyc_stb", {bus_a.i_cyc, bus_a.i_stb}, 2'b11);
    check("adr", bus_a.i_adr, eadr);
    check("sel", bus_a.i_sel, esel);
    check("we", bus_a.i_we, gd ? wr : 1'b0);
    check("dat_w", bus_a.i_dat_w, edatw);
    check("ready_busy", {bus_a.iBus_cmd_ready, bus_a.dBus_cmd_ready}, 2'b00);
    obs_sel = bus_a.i_sel; obs_we = bus_a.i_we; obs_datw = bus_a.i_dat_w; obs_d = gd;
    hold_ok = 1'b1;
    done = 1'b0;
    for (int k = 0; k < 16 && !done; k++) begin
      if (!noack && k == dly) begin
        bus_a.i_ack = err ? 1'($urandom % 2) : 1'b1;
        bus_a.i_err = err;
      end
      @(posedge clock); #1;
      bus_a.i_ack = 1'b0;
      bus_a.i_err = 1'b0;
      if ((!noack && k == dly) || (noack && k == TO - 1)) done = 1'b1;
      else if (!(bus_a.i_cyc && bus_a.i_stb) || bus_a.i_adr != eadr || bus_a.i_sel != esel ||
               bus_a.iBus_rsp_valid || bus_a.dBus_rsp_ready) hold_ok = 1'b0;
    end
    check("completed", done, 1);
    check("hold_stable", hold_ok, 1);
    check("cyc_drop", {bus_a.i_cyc, bus_a.i_stb}, 2'b00);
    exp_err  = noack ? 1'b1 : err;
    exp_data = noack ? 32'h0 : rdata;
    if (gd) begin
      check("d_rsp_pulse", {bus_a.dBus_rsp_ready, bus_a.iBus_rsp_valid}, 2'b10);
      check("d_rsp_err", bus_a.dBus_rsp_error, exp_err);
      check("d_rsp_data", bus_a.dBus_rsp_data, exp_data);
      m_d_data = exp_data;
    end else begin
      check("i_rsp_pulse", {bus_a.dBus_rsp_ready, bus_a.iBus_rsp_valid}, 2'b01);
      check("i_rsp_err", bus_a.iBus_rsp_payload_error, exp_err);
      check("i_rsp_inst", bus_a.iBus_rsp_payload_inst, exp_data);
      m_i_inst = exp_data;
    end
    n = 0;
    pulse_ok = 1'b1;
    while (!(bus_a.iBus_cmd_ready || bus_a.dBus_cmd_ready) && n < 10) begin
      n++;
      @(posedge clock); #1;
      if (bus_a.iBus_rsp_valid || bus_a.dBus_rsp_ready) pulse_ok = 1'b0;
    end
    check("turnaround", n, TURN);
    check("pulse_len", pulse_ok, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [3:0] order;
    logic pulse_ok;
    int dg, ig, pick;
    bus_a.iBus_cmd_valid = 0; bus_a.iBus_cmd_payload_pc = 0;
    bus_a.dBus_cmd_valid = 0; bus_a.dBus_cmd_payload_wr = 0;
    bus_a.dBus_cmd_payload_address = 0; bus_a.dBus_cmd_payload_data = 0;
    bus_a.dBus_cmd_payload_size = 0;
    bus_a.i_dat_r = 0; bus_a.i_ack = 0; bus_a.i_err = 0;
    bus_b.iBus_cmd_valid = 0; bus_b.iBus_cmd_payload_pc = 32'h100;
    bus_b.dBus_cmd_valid = 0; bus_b.dBus_cmd_payload_wr = 0;
    bus_b.dBus_cmd_payload_address = 32'h200; bus_b.dBus_cmd_payload_data = 0;
    bus_b.dBus_cmd_payload_size = 2; bus_b.i_dat_r = 32'h5A5A5A5A; bus_b.i_err = 0;
    m_last_i = 1'b1; m_d_data = 0; m_i_inst = 0;

    vecs[0] = '{1'b0, 32'h0000_1000, 2'd2, 32'h0,         32'hDEADBEEF, 3, 4'b1111};
    vecs[1] = '{1'b1, 32'h0000_2001, 2'd0, 32'h1122_3344, 32'h0000_0001, 0, 4'b0010};
    vecs[2] = '{1'b1, 32'h0000_2003, 2'd0, 32'h5566_7788, 32'h0000_0002, 1, 4'b1000};
    vecs[3] = '{1'b1, 32'h0000_2002, 2'd1, 32'h99AA_BBCC, 32'h0000_0003, 2, 4'b1100};
    vecs[4] = '{1'b1, 32'h0000_2000, 2'd1, 32'hCAFE_F00D, 32'h0000_0004, 0, 4'b0011};
    vecs[5] = '{1'b0, 32'h0000_3000, 2'd0, 32'h0,         32'h1234_5678, 4, 4'b0001};
    vecs[6] = '{1'b0, 32'h0000_3002, 2'd0, 32'h0,         32'h8765_4321, 1, 4'b0100};
    vecs[7] = '{1'b1, 32'h0000_4001, 2'd3, 32'hA5A5_0F0F, 32'h0000_0005, 5, 4'b1111};

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("rst_cyc", {bus_a.i_cyc, bus_a.i_stb}, 2'b00);
    check("rst_ready", {bus_a.iBus_cmd_ready, bus_a.dBus_cmd_ready}, 2'b00);
    check("rst_rsp", {bus_a.iBus_rsp_valid, bus_a.dBus_rsp_ready}, 2'b00);
    check("rst_sel", bus_a.i_sel, 4'b0000);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("idle_ready_d", bus_a.dBus_cmd_ready, model_pick_d(1'b0, 1'b0, m_last_i));
    check("idle_ready_i", bus_a.iBus_cmd_ready, !model_pick_d(1'b0, 1'b0, m_last_i));

    // Directed dBus accesses
    foreach (vecs[i]) begin
      run_txn(1'b0, 1'b1, 32'h0, vecs[i].wr, vecs[i].addr, vecs[i].size, vecs[i].wdata,
              vecs[i].rdata, vecs[i].dly, 1'b0, 1'b0);
      check("tbl_sel", obs_sel, vecs[i].exp_sel);
      check("tbl_we", obs_we, vecs[i].wr);
      check("tbl_dat_w", obs_datw, vecs[i].wdata);
    end

    // Fetch that the slave answers with err
    run_txn(1'b1, 1'b0, 32'h80, 1'b0, 32'h0, 2'd2, 32'h0, 32'h0BAD_0BAD, 1, 1'b1, 1'b0);

    // Simultaneous requests alternate under round-robin
    order = '0;
    for (int t = 0; t < 4; t++) begin
      run_txn(1'b1, 1'b1, 32'h0000_0100 + 32'(t * 4), 1'b0, 32'h0000_7000 + 32'(t * 4), 2'd2,
              32'h0, 32'h7000_0000 + 32'(t), 0, 1'b0, 1'b0);
      order[3 - t] = obs_d;
    end
    check("rr_order", order, 4'b1010);

    // Slave never responds: timeout abort
    run_txn(1'b0, 1'b1, 32'h0, 1'b0, 32'h0000_6000, 2'd2, 32'h0, 32'hFFFF_FFFF, 0, 1'b0, 1'b1);

    // Randomized traffic
    for (int r = 0; r < 40; r++) begin
      pick = $urandom % 3;
      run_txn(pick != 1, pick != 0, $urandom & 32'hFFFF_FFFC, 1'($urandom % 2), $urandom,
              2'($urandom % 4), $urandom, $urandom, $urandom % 7, ($urandom % 5) == 0,
              ($urandom % 8) == 0);
    end

    // Reset in the middle of a data cycle
    @(negedge clock);
    bus_a.dBus_cmd_valid = 1'b1;
    bus_a.dBus_cmd_payload_wr = 1'b0;
    bus_a.dBus_cmd_payload_address = 32'h0000_5000;
    bus_a.dBus_cmd_payload_size = 2'd2;
    #1;
    check("pre_rst_ready", bus_a.dBus_cmd_ready, model_pick_d(1'b0, 1'b1, m_last_i));
    @(posedge clock); #1;
    bus_a.dBus_cmd_valid = 1'b0;
    check("pre_rst_cyc", bus_a.i_cyc, 1);
    @(negedge clock); #2;
    reset = 1'b1;
    #1;
    check("mid_rst_cyc", {bus_a.i_cyc, bus_a.i_stb}, 2'b00);
    check("mid_rst_rsp", {bus_a.iBus_rsp_valid, bus_a.dBus_rsp_ready}, 2'b00);
    check("mid_rst_data", bus_a.dBus_rsp_data, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    m_last_i = 1'b1; m_d_data = 0; m_i_inst = 0;
    pulse_ok = 1'b1;
    repeat (4) begin
      @(posedge clock); #1;
      if (bus_a.iBus_rsp_valid || bus_a.dBus_rsp_ready || bus_a.i_cyc) pulse_ok = 1'b0;
    end
    check("post_rst_quiet", pulse_ok, 1);
    run_txn(1'b0, 1'b1, 32'h0, 1'b1, 32'h0000_5004, 2'd2, 32'h0102_0304, 32'h0000_00AA, 2,
            1'b0, 1'b0);

    // Fixed priority, zero turnaround: dBus takes every other cycle, iBus starves
    dg = 0;
    ig = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (i == 0) begin
        bus_b.iBus_cmd_valid = 1'b1;
        bus_b.dBus_cmd_valid = 1'b1;
      end
      #1;
      if (bus_b.dBus_cmd_valid && bus_b.dBus_cmd_ready) dg++;
      if (bus_b.iBus_cmd_valid && bus_b.iBus_cmd_ready) ig++;
    end
    bus_b.iBus_cmd_valid = 1'b0;
    bus_b.dBus_cmd_valid = 1'b0;
    check("fixed_d_grants", dg, 6);
    check("fixed_i_grants", ig, 0);
    repeat (3) @(posedge clock);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
